// File: rtl/silicon_net_injector_pkg.sv
// Shared types for the switch injection port: flit interface, credit return, FSM states.
// Widths are fixed here so the top, the credit counter and the bench agree on packing.
package silicon_net_injector_pkg;

  function automatic int port_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_PORTS        = 8;
  localparam int PORT_WIDTH       = port_width(NUM_PORTS);
  localparam int FLIT_WIDTH       = 64;
  localparam int MAX_CREDIT_WIDTH = 5;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [PORT_WIDTH-1:0] dst_port;
    logic                  head;
    logic                  tail;
  } switch_ifc_t;

  typedef struct packed {
    logic                        valid;
    logic [MAX_CREDIT_WIDTH-1:0] count;
  } switch_credit_t;

  typedef enum logic {
    ST_HEAD = 1'b0,
    ST_BODY = 1'b1
  } inj_state_e;

endpackage

// File: rtl/silicon_net_injector_credit_counter.sv
// Credit return handshake (one-cycle ack per accepted credit) and saturating credit counter.
// Overflow beyond the downstream limit saturates the count and raises a sticky error.
module silicon_net_injector_credit_counter
  import silicon_net_injector_pkg::*;
#(
  parameter int MAX_FLITS_PER_PORT_DOWNSTREAM = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  switch_credit_t              credit_i,
  input  logic                        flit_acc_i,
  output logic                        credack_o,
  output logic [MAX_CREDIT_WIDTH-1:0] credits_o,
  output logic                        error_o
);

  localparam int SUM_W = MAX_CREDIT_WIDTH + 2;

  logic [MAX_CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic                        ack_q, err_q, err_d;
  logic                        credit_acc;
  logic [SUM_W-1:0]            sum;

  // A credit presented while our ack is high belongs to the previous handshake.
  assign credit_acc = credit_i.valid && !ack_q;

  always_comb begin
    sum       = SUM_W'(credits_q)
              + (credit_acc ? SUM_W'(credit_i.count) : SUM_W'(0))
              - SUM_W'(flit_acc_i);
    credits_d = sum[MAX_CREDIT_WIDTH-1:0];
    err_d     = err_q;
    if (sum > SUM_W'(MAX_FLITS_PER_PORT_DOWNSTREAM)) begin
      credits_d = MAX_CREDIT_WIDTH'(MAX_FLITS_PER_PORT_DOWNSTREAM);
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      ack_q     <= credit_acc;
      err_q     <= err_d;
    end
  end

  assign credack_o = ack_q;
  assign credits_o = credits_q;
  assign error_o   = err_q;

endmodule

// File: rtl/silicon_net_injector.sv
// Client-to-switch injector: frames flits into messages with head/tail and a per-message dst.
// One registered output pulse per accepted flit; client is ready whenever credits are nonzero.
module silicon_net_injector
  import silicon_net_injector_pkg::*;
#(
  parameter int FLITS_PER_MESSAGE             = 4,
  parameter int MAX_FLITS_PER_PORT_DOWNSTREAM = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_WIDTH-1:0]       client_data_in,
  input  logic [PORT_WIDTH-1:0]       client_dst_in,
  input  logic                        client_valid_in,
  output logic                        client_ready_out,
  output switch_ifc_t                 output_ifc_out,
  output logic                        output_valid_out,
  input  switch_credit_t              credit_in,
  output logic                        credack_out,
  output logic [MAX_CREDIT_WIDTH-1:0] credits_out,
  output logic                        error_out
);

  localparam int IDX_W = (FLITS_PER_MESSAGE > 1) ? $clog2(FLITS_PER_MESSAGE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLITS_PER_MESSAGE - 1);

  inj_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PORT_WIDTH-1:0] dst_q, dst_d;
  switch_ifc_t           ifc_q, ifc_d;
  logic                  vld_q;
  logic                  flit_acc;
  logic                  last;

  silicon_net_injector_credit_counter #(
    .MAX_FLITS_PER_PORT_DOWNSTREAM(MAX_FLITS_PER_PORT_DOWNSTREAM)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .credit_i  (credit_in),
    .flit_acc_i(flit_acc),
    .credack_o (credack_out),
    .credits_o (credits_out),
    .error_o   (error_out)
  );

  assign client_ready_out = (credits_out != '0);
  assign flit_acc         = client_valid_in && client_ready_out;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dst_d   = dst_q;
    ifc_d   = ifc_q;
    last    = (idx_q == LAST_IDX);
    if (flit_acc) begin
      case (state_q)
        ST_HEAD: begin
          dst_d = client_dst_in;
          ifc_d = '{data: client_data_in, dst_port: client_dst_in, head: 1'b1,
                    tail: (FLITS_PER_MESSAGE == 1)};
          if (FLITS_PER_MESSAGE == 1) begin
            idx_d = '0;
          end else begin
            idx_d   = IDX_W'(1);
            state_d = ST_BODY;
          end
        end
        default: begin
          // Body flits keep the destination latched at the head; client_dst_in is ignored.
          ifc_d = '{data: client_data_in, dst_port: dst_q, head: 1'b0, tail: last};
          if (last) begin
            idx_d   = '0;
            state_d = ST_HEAD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HEAD;
      idx_q   <= '0;
      dst_q   <= '0;
      ifc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dst_q   <= dst_d;
      ifc_q   <= ifc_d;
      vld_q   <= flit_acc;
    end
  end

  assign output_ifc_out   = ifc_q;
  assign output_valid_out = vld_q;

endmodule
